// File: rtl/ysyx_24080006_hpm_pkg.sv
// Shared definitions for the hardware performance monitor: CSR op encoding,
// counter-range CSR addresses and mhpmevent field layout.
package ysyx_24080006_hpm_pkg;

  typedef enum logic [1:0] {
    CSR_READ  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csr_op_e;

  localparam logic [11:0] CSR_MCOUNTINHIBIT   = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT3      = 12'h323;
  localparam logic [11:0] CSR_MHPMEVENT31     = 12'h33F;
  localparam logic [11:0] CSR_MCYCLE          = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET        = 12'hB02;
  localparam logic [11:0] CSR_MHPMCOUNTER3    = 12'hB03;
  localparam logic [11:0] CSR_MHPMCOUNTER31   = 12'hB1F;
  localparam logic [11:0] CSR_MCYCLEH         = 12'hB80;
  localparam logic [11:0] CSR_MHPMCOUNTER31H  = 12'hB9F;

  localparam int HPM_OF_BIT = 31;
  localparam int HPM_SEL_W  = 8;

  // One bit per counter slot that physically exists: mcycle, minstret and
  // mhpmcounter3..(2+num_hpm). Slot 1 (time) never lives here.
  function automatic logic [31:0] hpm_impl_mask(input int num_hpm);
    logic [31:0] m;
    m    = '0;
    m[0] = 1'b1;
    m[2] = 1'b1;
    for (int k = 3; k < 3 + num_hpm; k++) m[k] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/ysyx_24080006_hpm_counter.sv
// One CNT_W-bit event counter with independently writable 32-bit halves.
// A software write to either half suppresses the increment for that cycle.
module ysyx_24080006_hpm_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             incr_en,
  input  logic             lo_we,
  input  logic             hi_we,
  input  logic [31:0]      wdata,
  output logic [CNT_W-1:0] value,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_q;

  // Counter register: software write has priority over the increment.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (lo_we || hi_we) begin
      if (lo_we) cnt_q[31:0]       <= wdata;
      if (hi_we) cnt_q[CNT_W-1:32] <= wdata[CNT_W-33:0];
    end else if (incr_en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign value = cnt_q;
  assign wrap  = incr_en && !(lo_we || hi_we) && (&cnt_q);

endmodule

// File: rtl/ysyx_24080006_hpm.sv
// Machine-mode performance monitor: mcycle, minstret, NUM_HPM programmable
// counters with event selectors, mcountinhibit and sticky overflow flags.
module ysyx_24080006_hpm
  import ysyx_24080006_hpm_pkg::*;
#(
  parameter int NUM_HPM    = 9,
  parameter int CNT_W      = 64,
  parameter int NUM_EVENTS = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  csr_en,
  input  csr_op_e               csr_op,
  input  logic [11:0]           csr_addr,
  input  logic [31:0]           csr_wdata,
  output logic [31:0]           csr_rdata,
  output logic                  csr_illegal,
  input  logic                  instret,
  input  logic [NUM_EVENTS-1:0] events,
  output logic                  overflow
);

  localparam logic [31:0] IMPL_MASK = hpm_impl_mask(NUM_HPM);

  logic [4:0]           idx;
  logic                 is_inh, is_evt, is_lo, is_hi;
  logic                 we;
  logic [31:0]          wval;
  logic [31:0]          inh_q;
  logic [31:0]          cnt_hi_rd;
  logic [255:0]         ev_ext;
  logic [CNT_W-1:0]     cnt    [32];
  logic [HPM_SEL_W-1:0] sel_q  [32];
  logic [31:0]          of_vec;

  assign idx    = csr_addr[4:0];
  assign is_inh = (csr_addr == CSR_MCOUNTINHIBIT);
  assign is_evt = (csr_addr >= CSR_MHPMEVENT3) && (csr_addr <= CSR_MHPMEVENT31);
  assign is_lo  = (csr_addr >= CSR_MCYCLE) && (csr_addr <= CSR_MHPMCOUNTER31) && (idx != 5'd1);
  assign is_hi  = (csr_addr >= CSR_MCYCLEH) && (csr_addr <= CSR_MHPMCOUNTER31H) && (idx != 5'd1);
  assign csr_illegal = !(is_inh || is_evt || is_lo || is_hi);

  // Upper counter half, zero-extended for the high-half CSR view.
  always_comb begin
    cnt_hi_rd              = '0;
    cnt_hi_rd[CNT_W-33:0]  = cnt[idx][CNT_W-1:32];
  end

  // Read mux; unimplemented slots already read as zero.
  always_comb begin
    csr_rdata = '0;
    if (is_inh)      csr_rdata = inh_q;
    else if (is_evt) csr_rdata = {of_vec[idx], 23'b0, sel_q[idx]};
    else if (is_lo)  csr_rdata = cnt[idx][31:0];
    else if (is_hi)  csr_rdata = cnt_hi_rd;
  end

  // Write enable and read-modify-write value; SET/CLEAR of zero is a pure read.
  always_comb begin
    we = csr_en && !csr_illegal &&
         ((csr_op == CSR_WRITE) ||
          (((csr_op == CSR_SET) || (csr_op == CSR_CLEAR)) && (csr_wdata != 32'd0)));
    case (csr_op)
      CSR_SET:   wval = csr_rdata | csr_wdata;
      CSR_CLEAR: wval = csr_rdata & ~csr_wdata;
      default:   wval = csr_wdata;
    endcase
  end

  // Event vector shifted up by one so selector value 0 always reads as no event.
  always_comb begin
    ev_ext = '0;
    for (int k = 1; k <= NUM_EVENTS; k++) ev_ext[k] = events[k-1];
  end

  // mcountinhibit; the new value governs increments from the next cycle.
  always_ff @(posedge clock) begin
    if (reset)                inh_q <= '0;
    else if (we && is_inh)    inh_q <= wval & IMPL_MASK;
  end

  for (genvar i = 0; i < 32; i++) begin : g_slot
    if (i == 0 || i == 2) begin : g_fixed
      logic wrap_unused;
      logic incr;
      assign incr = (i == 0) ? !inh_q[i] : (instret && !inh_q[i]);
      ysyx_24080006_hpm_counter #(.CNT_W(CNT_W)) u_cnt (
        .clock   (clock),
        .reset   (reset),
        .incr_en (incr),
        .lo_we   (we && is_lo && (idx == 5'(i))),
        .hi_we   (we && is_hi && (idx == 5'(i))),
        .wdata   (wval),
        .value   (cnt[i]),
        .wrap    (wrap_unused)
      );
      assign sel_q[i]  = '0;
      assign of_vec[i] = 1'b0;
    end else if (i >= 3 && i < 3 + NUM_HPM) begin : g_hpm
      logic                 wrap;
      logic                 incr;
      logic                 evt_we;
      logic [HPM_SEL_W-1:0] sel_r;
      logic                 of_r;
      assign incr   = ev_ext[sel_r] && !inh_q[i];
      assign evt_we = we && is_evt && (idx == 5'(i));
      ysyx_24080006_hpm_counter #(.CNT_W(CNT_W)) u_cnt (
        .clock   (clock),
        .reset   (reset),
        .incr_en (incr),
        .lo_we   (we && is_lo && (idx == 5'(i))),
        .hi_we   (we && is_hi && (idx == 5'(i))),
        .wdata   (wval),
        .value   (cnt[i]),
        .wrap    (wrap)
      );
      // mhpmevent: a hardware wrap forces OF even against a software write.
      always_ff @(posedge clock) begin
        if (reset) begin
          sel_r <= '0;
          of_r  <= 1'b0;
        end else if (evt_we) begin
          sel_r <= wval[HPM_SEL_W-1:0];
          of_r  <= wval[HPM_OF_BIT] || wrap;
        end else if (wrap) begin
          of_r  <= 1'b1;
        end
      end
      assign sel_q[i]  = sel_r;
      assign of_vec[i] = of_r;
    end else begin : g_none
      assign cnt[i]    = '0;
      assign sel_q[i]  = '0;
      assign of_vec[i] = 1'b0;
    end
  end

  assign overflow = |of_vec;

endmodule

// File: doc/ysyx_24080006_hpm.md
# ysyx_24080006_hpm

Parametrised machine-mode hardware performance monitor. It replaces the fixed mcycle/minstret/mhpmcounter set in the CSR file with programmable counters. It provides mcycle, minstret and NUM_HPM programmable mhpmcounterN with mhpmeventN selectors, software-writable counters, a writable mcountinhibit, and sticky overflow flags with an aggregated overflow output. It sits beside the CSR file in the core; the CSR file forwards counter-range accesses to it and muxes `csr_rdata` back.

## Interface
- NUM_HPM, default 9: programmable counters, mhpmcounter3..mhpmcounter(2+NUM_HPM); legal range 0..29.
- CNT_W, default 64: counter width; legal range 33..64.
- NUM_EVENTS, default 16: width of the event input vector; legal range 1..255.
- clock  input  1: sole clock.
- reset  input  1: synchronous, active-high.
- csr_en  input  1: CSR access this cycle.
- csr_op  input  csr_op_e: READ/WRITE/SET/CLEAR.
- csr_addr  input  12: CSR address.
- csr_wdata  input  32: write operand.
- csr_rdata  output  32: read data, combinational from current state.
- csr_illegal  output  1: address is not in this block's map (only meaningful when csr_en is high).
- instret  input  1: one instruction retired this cycle.
- events  input  NUM_EVENTS: per-cycle event pulses.
- overflow  output  1: OR of all overflow flags.

## Operation
- Address map:
  - mcountinhibit 0x320.
  - mhpmevent3..31 at 0x323..0x33F.
  - mcycle 0xB00, minstret 0xB02, mhpmcounter3..31 at 0xB03..0xB1F.
  - High halves at 0xB80, 0xB82, 0xB83..0xB9F.
  - Anything else, including 0xB01/0xB81: csr_illegal=1, rdata=0, no write.
- Unimplemented counter indices (≥3+NUM_HPM): mhpmcounter and mhpmevent read 0, writes ignored, not illegal.
- Write enable: csr_en & ~csr_illegal & op∈{WRITE,SET,CLEAR}. SET/CLEAR with csr_wdata==0 is not a write.
- Write value by op:
  - WRITE: wdata.
  - SET: rdata|wdata.
  - CLEAR: rdata&~wdata.
- Low-half read: counter[31:0]. High-half read: counter[CNT_W-1:32], zero-extended to 32 bits.
- Counter write:
  - Low-half write replaces bits [31:0].
  - High-half write replaces bits [CNT_W-1:32], truncating wdata.
  - The other half is kept.
- mcountinhibit:
  - Bit 1 and bits for unimplemented counters are hardwired 0.
  - Bit i=1 freezes counter i.
- Increment conditions, each subject to inhibit:
  - mcycle: every cycle.
  - minstret: when instret is high.
  - mhpmcounterN: when sel=mhpmeventN[7:0] is in 1..NUM_EVENTS and events[sel-1] is high. sel=0 or sel>NUM_EVENTS: never counts.
- mhpmeventN fields:
  - Writable bits are [7:0] and [31] (OF); all other bits read 0.
  - OF is set when an increment wraps the counter from all-ones to 0.
  - Software writes OF directly.
- overflow = OR of all OF bits. mcycle/minstret have no OF.
- Simultaneous events:
  - Software write to either half of a counter in the same cycle as its increment: the write wins, and the whole counter does not increment that cycle.
  - Hardware OF set and software write to the same mhpmevent: OF=1 wins, and the other fields take the written value.

## Timing
- Reset, at the next posedge with reset high: all counters, mhpmevents and mcountinhibit are 0, overflow=0. csr_rdata is 0 for every counter address.
- Reset asserted mid-operation: pending writes and increments in that cycle are discarded.
- csr_rdata and csr_illegal: combinational, zero-cycle latency, reflecting pre-edge state.
- Writes and increments take effect at the clock edge ending the cycle; they are visible to a read in the following cycle.
- overflow is registered: it rises in the cycle after the wrapping increment.
- Inhibit written in cycle t applies to increments from cycle t+1. Cycle t still counts under the old inhibit value.
- Carry from the low half into the high half is within the same cycle; the full CNT_W-bit add is done in one cycle.

## Structure
- Shared package additions:
  - CSR address constants MHPMEVENT3..31 and MCOUNTINHIBIT, where missing.
  - OF bit-position constant (31) and event-select field width (8).
  - csr_op_e is reused from the package.
- Sub-module ysyx_24080006_hpm_counter, parametrised by CNT_W:
  - Inputs: incr_en, lo_we, hi_we, wdata.
  - Outputs: value, wrap pulse.
  - Instantiated 2+NUM_HPM times via generate.
- The top level holds the address decode, the mhpmevent/mcountinhibit registers, the event-select muxes and OF/overflow logic.

## Test plan
- Reset, then idle for 10 cycles: mcycle low reads 10, minstret reads 0, overflow=0. Reading 0xB01 gives csr_illegal=1.
- WRITE mhpmevent3=2, then pulse events[1] for 5 cycles: mhpmcounter3=5. Repeat with sel=0 and with sel=NUM_EVENTS+1: counter stays at 0.
- WRITE mcycle low=0xFFFFFFFF, then wait 1 cycle: low=0, high=1, so carry crosses halves. Writing mcycle low in the same cycle as a tick leaves exactly the written value.
- WRITE mhpmcounter3 high=0xFFFFFFFF and low=0xFFFFFFFE with CNT_W=64, then give 2 events: counter wraps to 0, mhpmevent3[31]=1, overflow=1 one cycle later. CLEAR bit 31: overflow=0. A wrap coincident with that CLEAR leaves OF=1.
- SET mcountinhibit=0x5, then run 4 cycles with instret high: mcycle and minstret frozen, mhpmcounter3 keeps counting. Reading mcountinhibit returns 0x5, and writing bit 1 reads back 0.
- Assert reset mid-count for 1 cycle with NUM_HPM=2: all registers are 0. mhpmcounter5 and mhpmevent5 read 0, ignore writes, and csr_illegal=0.
